aes128_encr_round_ctrl: RTL and testbench

- Iterative AES-128 encryption controller: sequences one full round per clock over the team's combinational round blocks (sub-bytes, shift-rows, mix-columns, add-round-key).
- Expands the round key on the fly, one round key per cycle.
- Sits between the chip I/O shift interface and the cipher datapath; valid/ready on both sides.

---
 rtl/aes_encr_pkg.sv | 84 ++++++++
 rtl/aes128_key_expand_step.sv | 28 ++
 rtl/aes128_encr_round_ctrl.sv | 112 +++++++++++
 tb/tb_aes128_encr_round_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_encr_pkg.sv
// Shared AES-128 constants, controller state encoding and the GF(2^8)/round helpers
// used by both the round datapath and the key schedule.
package aes_encr_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [3:0] idx;
    idx = rnd - 4'd1;
    if (rnd >= 4'd1 && rnd <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; i = row + 4*column
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_key_expand_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes128_key_expand_step
  import aes_encr_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0   = rk[127:96];
    w1   = rk[95:64];
    w2   = rk[63:32];
    w3   = rk[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_encr_round_ctrl.sv
// Iterative AES-128 encryption controller: one full round and one key-schedule step per clock.
//   state | meaning
//   IDLE  | waiting for a plaintext/key block, in_ready high
//   ROUND | applying rounds 1..NUM_ROUNDS, busy high
//   DONE  | ciphertext presented, held until out_ready
module aes128_encr_round_ctrl
  import aes_encr_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int RCNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      plaintext,
  input  logic [127:0]      key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ciphertext,
  output logic              busy,
  output logic [RCNT_W-1:0] round_cnt
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_encr_round_ctrl: NUM_ROUNDS must be 10 for AES-128");
  end
  if ((1 << RCNT_W) <= NUM_ROUNDS) begin : g_bad_rcnt_w
    $error("aes128_encr_round_ctrl: RCNT_W too narrow for NUM_ROUNDS");
  end

  localparam logic [RCNT_W-1:0] LAST_RND = RCNT_W'(NUM_ROUNDS);

  ctrl_state_e       state_q, state_d;
  logic [127:0]      st_reg, rk_reg, rk_next;
  logic [127:0]      sr_out, rnd_out;
  logic [RCNT_W-1:0] rcnt_q;
  logic [7:0]        rcon_cur;
  logic              last_rnd;

  assign last_rnd = (rcnt_q == LAST_RND);
  assign rcon_cur = rcon_of(4'(rcnt_q));

  aes128_key_expand_step u_key_expand (
    .rk      (rk_reg),
    .rcon    (rcon_cur),
    .rk_next (rk_next)
  );

  // Final round drops MixColumns
  always_comb begin
    sr_out  = shift_rows(sub_bytes(st_reg));
    rnd_out = (last_rnd ? sr_out : mix_columns(sr_out)) ^ rk_next;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ROUND;
      ROUND:   if (last_rnd)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      ROUND:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg <= '0;
      rk_reg <= '0;
      rcnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_reg <= plaintext ^ key;
            rk_reg <= key;
            rcnt_q <= RCNT_W'(1);
          end
        end
        ROUND: begin
          st_reg <= rnd_out;
          rk_reg <= rk_next;
          rcnt_q <= last_rnd ? '0 : rcnt_q + RCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = st_reg;
  assign round_cnt  = rcnt_q;

  a_rcnt_range: assert property (@(posedge clk) disable iff (rst) rcnt_q <= LAST_RND);

endmodule

// File: tb/tb_aes128_encr_round_ctrl.sv
// Directed bench for aes128_encr_round_ctrl with a ciphertext scoreboard queue.
module tb_aes128_encr_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] sb_q[$];

  aes128_encr_round_ctrl #(.NUM_ROUNDS(10), .RCNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic void pop_chk(input string tag);
    logic [127:0] e;
    if (sb_q.size() == 0) e = 'x;
    else                  e = sb_q.pop_front();
    chk(tag, ciphertext, e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [127:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    step(); step();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_round_cnt", 128'(round_cnt), 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    rst = 1'b0;
    step();

    // App. B vector, inputs toggled to all-ones after accept, then backpressure
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    chk("b_in_ready_pre", 128'(in_ready), 128'd1);
    step();
    sb_q.push_back(CT_B);
    in_valid = 1'b0; plaintext = '1; key = '1;
    chk("b_busy", 128'(busy), 128'd1);
    chk("b_in_ready_round", 128'(in_ready), 128'd0);
    chk("b_round_cnt1", 128'(round_cnt), 128'd1);
    wait_out(lat);
    chk("b_latency", 128'(lat), 128'd10);
    chk("b_out_valid", 128'(out_valid), 128'd1);
    chk("b_round_cnt_done", 128'(round_cnt), 128'd0);
    held = ciphertext;
    pop_chk("b_ct");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_ct_stable", ciphertext, held);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b0;
    step();

    // Back-to-back: in_valid held, second block presented right after the first accept
    out_ready = 1'b1;
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    step();
    sb_q.push_back(CT_B);
    plaintext = PT_C; key = KEY_C;
    wait_out(lat);
    chk("bb1_latency", 128'(lat), 128'd10);
    pop_chk("bb1_ct");
    chk("bb1_no_accept_in_done", 128'(in_ready), 128'd0);
    step();
    chk("bb1_hs_out_valid", 128'(out_valid), 128'd0);
    chk("bb1_hs_in_ready", 128'(in_ready), 128'd1);
    step();
    sb_q.push_back(CT_C);
    in_valid = 1'b0;
    chk("bb2_busy", 128'(busy), 128'd1);
    chk("bb2_round_cnt1", 128'(round_cnt), 128'd1);
    wait_out(lat);
    chk("bb2_latency", 128'(lat), 128'd10);
    pop_chk("bb2_ct");
    step();
    chk("bb2_hs_in_ready", 128'(in_ready), 128'd1);

    // Reset at round 5 aborts the block
    plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
    step();
    sb_q.push_back(CT_B);
    in_valid = 1'b0;
    lat = 0;
    while (round_cnt != 4'd5 && lat < 20) begin
      step();
      lat++;
    end
    chk("ab_reach_round5", 128'(round_cnt), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_front());
    chk("ab_in_ready", 128'(in_ready), 128'd1);
    chk("ab_out_valid", 128'(out_valid), 128'd0);
    chk("ab_round_cnt", 128'(round_cnt), 128'd0);
    chk("ab_busy", 128'(busy), 128'd0);
    chk("ab_ciphertext", ciphertext, 128'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ab_no_out_valid", 128'(out_valid), 128'd0);
    end

    plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
    step();
    sb_q.push_back(CT_C);
    in_valid = 1'b0;
    wait_out(lat);
    chk("c_latency", 128'(lat), 128'd10);
    pop_chk("c_ct");
    step();
    chk("c_hs_in_ready", 128'(in_ready), 128'd1);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
